// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the HD44780 read engine and the write controller.
//   - FSM state encodings (IDLE, SETUP, E_HIGH, E_LOW)
//   - ns/us to clock-cycle conversion, clamped to [1, 2^CNT_W-1]
//   - location of the busy flag and address-counter field in a status byte
package lcd_pkg;

  typedef logic [1:0] lcd_state_t;

  localparam lcd_state_t ST_IDLE   = 2'd0;
  localparam lcd_state_t ST_SETUP  = 2'd1;
  localparam lcd_state_t ST_E_HIGH = 2'd2;
  localparam lcd_state_t ST_E_LOW  = 2'd3;

  localparam int BF_BIT = 7;  // busy flag position in a status byte
  localparam int AC_MSB = 6;  // address counter occupies [AC_MSB:0]

  localparam int     CNT_W   = 24;
  localparam longint CNT_MAX = 64'sd16777215;

  function automatic logic [CNT_W-1:0] clamp_cycles(input longint n);
    longint c;
    c = n;
    if (c < 1) c = 1;
    if (c > CNT_MAX) c = CNT_MAX;
    return c[CNT_W-1:0];
  endfunction

  // N = max(1, CLK_FREQ/1e6 * T_ns / 1000)
  function automatic logic [CNT_W-1:0] ns_to_cycles(input longint clk_freq, input longint t_ns);
    return clamp_cycles((clk_freq / 1000000) * t_ns / 1000);
  endfunction

  function automatic logic [CNT_W-1:0] us_to_cycles(input longint clk_freq, input longint t_us);
    return clamp_cycles((clk_freq / 1000000) * t_us);
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: request/response and LCD pin bundle of the read engine.
//   slave  : the read engine (lcd_reader)
//   master : the requester together with the LCD data input path
interface lcd_reader_if;
  logic       req;
  logic       req_rs;
  logic [7:0] d_in;
  logic       rs;
  logic       rw;
  logic       e;
  logic       bus_release;
  logic       ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy_bit;
  logic [6:0] addr_count;
  logic       timeout;

  modport master (
    output req, req_rs, d_in,
    input  rs, rw, e, bus_release, ready, rd_valid, rd_data, busy_bit, addr_count, timeout
  );

  modport slave (
    input  req, req_rs, d_in,
    output rs, rw, e, bus_release, ready, rd_valid, rd_data, busy_bit, addr_count, timeout
  );
endinterface

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: load-and-count-down phase timer.
//   clock, internal_reset : clock and asynchronous active-high reset
//   load, load_val        : restart the count at load_val (use N-1 for an N-cycle phase)
//   done                  : high while the count is zero
// Counts down and saturates at zero, so it never wraps.
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic             clock,
  input  logic             internal_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle engine (RW=1 cycles for busy flag/AC or a RAM byte).
//   clock, internal_reset : clock and asynchronous active-high reset
//   bus (slave)           : req/req_rs in, d_in from the LCD, rs/rw/e pins,
//                           bus_release, ready, rd_valid/rd_data/busy_bit/addr_count,
//                           timeout
// Macro LCD_BUSY_POLL_EN: status requests repeat the read cycle while BF=1, aborting
// with a timeout pulse after POLL_TIMEOUT_US. Without it every request is one cycle
// and timeout stays 0.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ        = 100000000,
  parameter int T_AS_NS         = 50,
  parameter int T_EH_NS         = 250,
  parameter int T_EL_NS         = 250,
  parameter int POLL_TIMEOUT_US = 2000
) (
  input  logic     clock,
  input  logic     internal_reset,
  lcd_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] AS_LD = ns_to_cycles(CLK_FREQ, T_AS_NS) - CNT_W'(1);
  localparam logic [CNT_W-1:0] EH_LD = ns_to_cycles(CLK_FREQ, T_EH_NS) - CNT_W'(1);
  localparam logic [CNT_W-1:0] EL_LD = ns_to_cycles(CLK_FREQ, T_EL_NS) - CNT_W'(1);

  lcd_state_t       state;
  logic             rs_q, rw_q, e_q, rel_q, ready_q, vld_q, to_q, bf_q;
  logic [7:0]       data_q;
  logic [6:0]       ac_q;
  logic             ph_load, ph_done;
  logic [CNT_W-1:0] ph_val;
  logic             start;
  logic             poll_again, poll_abort;

  assign start = (state == ST_IDLE) && bus.req;

`ifdef LCD_BUSY_POLL_EN
  localparam logic [CNT_W-1:0] TO_LD = us_to_cycles(CLK_FREQ, POLL_TIMEOUT_US) - CNT_W'(1);
  logic busy_seen, to_done;

  // Total poll time is measured from request acceptance, across all repeats.
  lcd_delay_counter u_poll_timer (
    .clock          (clock),
    .internal_reset (internal_reset),
    .load           (start),
    .load_val       (TO_LD),
    .done           (to_done)
  );

  assign busy_seen  = !rs_q && data_q[BF_BIT];
  assign poll_again = busy_seen && !to_done;
  assign poll_abort = busy_seen && to_done;
`else
  if (POLL_TIMEOUT_US < 1) begin : g_poll_param_check
    $error("POLL_TIMEOUT_US must be positive");
  end
  assign poll_again = 1'b0;
  assign poll_abort = 1'b0;
`endif

  // One timer serves all three phases; it is reloaded on each phase transition.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = AS_LD;
    unique case (state)
      ST_IDLE:   if (bus.req) begin ph_load = 1'b1; ph_val = AS_LD; end
      ST_SETUP:  if (ph_done) begin ph_load = 1'b1; ph_val = EH_LD; end
      ST_E_HIGH: if (ph_done) begin ph_load = 1'b1; ph_val = EL_LD; end
      ST_E_LOW:  if (ph_done && poll_again) begin ph_load = 1'b1; ph_val = AS_LD; end
      default:   ;
    endcase
  end

  lcd_delay_counter u_phase_timer (
    .clock          (clock),
    .internal_reset (internal_reset),
    .load           (ph_load),
    .load_val       (ph_val),
    .done           (ph_done)
  );

  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      state   <= ST_IDLE;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      rel_q   <= 1'b0;
      ready_q <= 1'b1;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      data_q  <= '0;
      bf_q    <= 1'b0;
      ac_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      to_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            rs_q    <= bus.req_rs;
            rw_q    <= 1'b1;
            rel_q   <= 1'b1;
            ready_q <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_done) begin
            e_q   <= 1'b1;
            state <= ST_E_HIGH;
          end
        end
        ST_E_HIGH: begin
          // d_in has settled well before the end of E high; sampled directly.
          if (ph_done) begin
            data_q <= bus.d_in;
            e_q    <= 1'b0;
            state  <= ST_E_LOW;
          end
        end
        ST_E_LOW: begin
          if (ph_done) begin
            if (poll_again) begin
              state <= ST_SETUP;  // rw/rs stay asserted between poll repeats
            end else begin
              rw_q    <= 1'b0;
              rel_q   <= 1'b0;
              ready_q <= 1'b1;
              state   <= ST_IDLE;
              if (!rs_q) begin
                bf_q <= data_q[BF_BIT];
                ac_q <= data_q[AC_MSB:0];
              end
              if (poll_abort) to_q  <= 1'b1;
              else            vld_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rs          = rs_q;
  assign bus.rw          = rw_q;
  assign bus.e           = e_q;
  assign bus.bus_release = rel_q;
  assign bus.ready       = ready_q;
  assign bus.rd_valid    = vld_q;
  assign bus.rd_data     = data_q;
  assign bus.busy_bit    = bf_q;
  assign bus.addr_count  = ac_q;
  assign bus.timeout     = to_q;

endmodule
